maxpool2d_size_2: RTL and testbench



---
 rtl/maxpool2d_size_2_pkg.sv | 27 ++
 rtl/maxpool2d_size_2_fp32_max.sv | 34 +++
 rtl/maxpool2d_size_2.sv | 105 ++++++++++
 tb/tb_maxpool2d_size_2.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2d_size_2_pkg.sv
// Shared definitions for the 2x2 max-pool stage: FP32 field helpers,
// counter width helper and the optional ReLU clamp.
package maxpool2d_size_2_pkg;

   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
   localparam int          FP32_SIGN_BIT = 31;
   localparam int          FP32_MAG_MSB  = 30;

   function automatic logic fp32_sign(input logic [31:0] x);
      return x[FP32_SIGN_BIT];
   endfunction

   function automatic logic [30:0] fp32_mag(input logic [31:0] x);
      return x[FP32_MAG_MSB:0];
   endfunction

   // Width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Any set sign bit, including -0.0, is clamped to +0.0.
   function automatic logic [31:0] relu(input logic [31:0] x, input bit en);
      return (en && fp32_sign(x)) ? FP32_POS_ZERO : x;
   endfunction

endpackage

// File: rtl/maxpool2d_size_2_fp32_max.sv
// Combinational FP32 max on the raw bit patterns; ties (including +0/-0)
// return a, so the earlier/upper operand wins.
module maxpool2d_size_2_fp32_max
   import maxpool2d_size_2_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic        sa;
   logic        sb;
   logic [30:0] ma;
   logic [30:0] mb;

   assign sa = fp32_sign(a);
   assign sb = fp32_sign(b);
   assign ma = fp32_mag(a);
   assign mb = fp32_mag(b);

   always_comb begin
      y = a;
      if ((ma == '0) && (mb == '0)) begin
         y = a;
      end else if (sa != sb) begin
         y = sa ? b : a;
      end else if (!sa) begin
         y = (mb > ma) ? b : a;
      end else begin
         y = (mb < ma) ? b : a;
      end
   end

endmodule

// File: rtl/maxpool2d_size_2.sv
// Streaming 2x2 stride-2 FP32 max-pool with optional ReLU; raster in,
// raster out, one-cycle latency from the pixel that completes a window.
module maxpool2d_size_2
   import maxpool2d_size_2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 56,
   parameter int IMG_HEIGHT = 56,
   parameter bit RELU_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [31:0]           data_out,
   output logic                  valid_out_pixel,
   output logic                  done
);

   localparam int LB_N  = IMG_WIDTH / 2;
   localparam int OUT_N = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
   localparam int COL_W = cnt_width(IMG_WIDTH);
   localparam int ROW_W = cnt_width(IMG_HEIGHT);
   localparam int OUT_W = cnt_width(OUT_N);
   localparam int LB_W  = cnt_width(LB_N);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [OUT_W-1:0] out_cnt;
   logic [31:0]      hold;
   logic [31:0]      lb [LB_N];

   logic [31:0]      pix;
   logic [31:0]      m;
   logic [31:0]      lb_rd;
   logic [31:0]      result;
   logic [LB_W-1:0]  lb_idx;
   logic             col_last;
   logic             row_last;
   logic             out_last;
   logic             fire;

   assign pix      = data_in[31:0];
   assign lb_idx   = LB_W'(col >> 1);
   assign lb_rd    = lb[lb_idx];
   assign col_last = (col == COL_W'(IMG_WIDTH - 1));
   assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
   assign out_last = (out_cnt == OUT_W'(OUT_N - 1));
   // Odd row and odd column closes a 2x2 window.
   assign fire     = data_valid_in && col[0] && row[0];

   maxpool2d_size_2_fp32_max u_max_h (
      .a (hold),
      .b (pix),
      .y (m)
   );

   maxpool2d_size_2_fp32_max u_max_v (
      .a (lb_rd),
      .b (m),
      .y (result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         col  <= '0;
         row  <= '0;
         hold <= FP32_POS_ZERO;
      end else if (data_valid_in) begin
         if (!col[0]) begin
            hold <= pix;
         end
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : ROW_W'(row + 1'b1);
         end else begin
            col <= COL_W'(col + 1'b1);
         end
      end
   end

   // Every entry is rewritten on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (!reset && data_valid_in && col[0] && !row[0]) begin
         lb[lb_idx] <= m;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out        <= FP32_POS_ZERO;
         valid_out_pixel <= 1'b0;
         done            <= 1'b0;
         out_cnt         <= '0;
      end else begin
         valid_out_pixel <= fire;
         done            <= fire && out_last;
         if (fire) begin
            data_out <= relu(result, RELU_EN);
            out_cnt  <= out_last ? '0 : OUT_W'(out_cnt + 1'b1);
         end
      end
   end

endmodule

// File: tb/tb_maxpool2d_size_2.sv
// Bench for maxpool2d_size_2: 4x4 instances (ReLU on/off) and a 56x56
// instance checked cycle-by-cycle against a numeric reference model.
module tb_maxpool2d_size_2;

   logic        clk = 1'b0;
   logic        reset;
   logic        v4, v56;
   logic [31:0] d4, d56;
   logic [31:0] oa, ob, oc;
   logic        va, vb, vc;
   logic        da, db, dc;

   always #5 clk = ~clk;

   maxpool2d_size_2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .data_valid_in(v4), .data_in(d4),
      .data_out(oa), .valid_out_pixel(va), .done(da));

   maxpool2d_size_2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .data_valid_in(v4), .data_in(d4),
      .data_out(ob), .valid_out_pixel(vb), .done(db));

   maxpool2d_size_2 #(.DATA_WIDTH(32), .IMG_WIDTH(56), .IMG_HEIGHT(56), .RELU_EN(1'b1)) dut_c (
      .clk(clk), .reset(reset), .data_valid_in(v56), .data_in(d56),
      .data_out(oc), .valid_out_pixel(vc), .done(dc));

   int errors = 0;
   int checks = 0;

   logic [31:0] frame4 [16];
   logic [31:0] big [3136];

   logic        p4_v, p4_done, pc_v, pc_done;
   logic [31:0] p_a, p_b, p_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Signed-magnitude mapped to a plain integer: +0 and -0 both map to 0.
   function automatic longint key(input logic [31:0] x);
      longint mag;
      mag = longint'(x[30:0]);
      return x[31] ? -mag : mag;
   endfunction

   function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
      return (key(b) > key(a)) ? b : a;
   endfunction

   function automatic logic [31:0] ref_relu(input logic [31:0] x, input bit en);
      return (en && x[31]) ? 32'h0 : x;
   endfunction

   // Max over the window whose top-left is (r,c), scanned in raster order.
   function automatic logic [31:0] window(input bit sel_big, input int w, input int r, input int c);
      logic [31:0] res;
      logic [31:0] p;
      int idx;
      res = 32'h0;
      for (int k = 0; k < 4; k++) begin
         idx = (r + k / 2) * w + c + k % 2;
         p   = sel_big ? big[idx] : frame4[idx];
         res = (k == 0) ? p : ref_max(res, p);
      end
      return res;
   endfunction

   function automatic logic [31:0] int_to_fp(input int n);
      int e;
      logic [31:0] x;
      e = 0;
      while ((1 << (e + 1)) <= n) e++;
      x = {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
      return x;
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] x;
      x = $urandom;
      if (x[30:23] == 8'hff) x[30] = 1'b0;
      return x;
   endfunction

   task automatic check4();
      chk("valid_a", {31'b0, va}, {31'b0, p4_v});
      chk("valid_b", {31'b0, vb}, {31'b0, p4_v});
      chk("done_a",  {31'b0, da}, {31'b0, p4_done});
      chk("done_b",  {31'b0, db}, {31'b0, p4_done});
      chk("data_a",  oa, p_a);
      chk("data_b",  ob, p_b);
   endtask

   task automatic checkc();
      chk("valid_c", {31'b0, vc}, {31'b0, pc_v});
      chk("done_c",  {31'b0, dc}, {31'b0, pc_done});
      chk("data_c",  oc, p_c);
   endtask

   task automatic cycle4(input logic v, input int idx);
      logic [31:0] w;
      @(negedge clk);
      check4();
      v4 = v;
      d4 = v ? frame4[idx] : $urandom;
      if (v && ((idx / 4) % 2 == 1) && (idx % 2 == 1)) begin
         w       = window(1'b0, 4, idx / 4 - 1, idx % 4 - 1);
         p4_v    = 1'b1;
         p4_done = (idx == 15);
         p_a     = ref_relu(w, 1'b1);
         p_b     = w;
      end else begin
         p4_v    = 1'b0;
         p4_done = 1'b0;
      end
   endtask

   task automatic feed4(input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, maxgap)) cycle4(1'b0, 0);
         cycle4(1'b1, i);
      end
   endtask

   task automatic rand_frame4();
      for (int i = 0; i < 16; i++) frame4[i] = rnd_fp();
   endtask

   initial begin
      int nv, nd;
      logic [31:0] w;

      reset = 1'b1;
      v4 = 1'b0; d4 = 32'h0; v56 = 1'b0; d56 = 32'h0;
      p4_v = 1'b0; p4_done = 1'b0; p_a = 32'h0; p_b = 32'h0;
      pc_v = 1'b0; pc_done = 1'b0; p_c = 32'h0;
      repeat (2) @(negedge clk);
      check4();
      checkc();
      reset = 1'b0;

      // Ascending 1..16 frame
      for (int i = 0; i < 16; i++) frame4[i] = int_to_fp(i + 1);
      feed4(16, 0);

      // All -1.0 with a single -3.0
      for (int i = 0; i < 16; i++) frame4[i] = 32'hbf800000;
      frame4[5] = 32'hc0400000;
      feed4(16, 0);

      // Signed-zero and mixed-sign windows
      rand_frame4();
      frame4[0] = 32'hc0000000; frame4[1] = 32'h3f000000;
      frame4[4] = 32'h80000000; frame4[5] = 32'h00000000;
      frame4[2] = 32'h80000000; frame4[3] = 32'h00000000;
      frame4[6] = 32'hbf800000; frame4[7] = 32'hc0000000;
      feed4(16, 0);

      // Same ascending frame with random idle gaps
      for (int i = 0; i < 16; i++) frame4[i] = int_to_fp(i + 1);
      feed4(16, 3);
      repeat (2) cycle4(1'b0, 0);

      // Two random frames back-to-back, then an aborted frame
      rand_frame4();
      feed4(16, 0);
      rand_frame4();
      feed4(16, 0);
      rand_frame4();
      feed4(5, 0);
      @(negedge clk);
      check4();
      reset = 1'b1;
      v4 = 1'b1;
      d4 = frame4[5];
      p4_v = 1'b0; p4_done = 1'b0; p_a = 32'h0; p_b = 32'h0;
      @(negedge clk);
      check4();
      reset = 1'b0;
      v4 = 1'b0;
      rand_frame4();
      feed4(16, 1);
      repeat (2) cycle4(1'b0, 0);

      // Full-size random frame
      for (int i = 0; i < 3136; i++) big[i] = rnd_fp();
      nv = 0;
      nd = 0;
      for (int i = 0; i < 3136; i++) begin
         @(negedge clk);
         checkc();
         if (vc) nv++;
         if (dc) nd++;
         v56 = 1'b1;
         d56 = big[i];
         if (((i / 56) % 2 == 1) && (i % 2 == 1)) begin
            w       = window(1'b1, 56, i / 56 - 1, i % 56 - 1);
            pc_v    = 1'b1;
            pc_done = (i == 3135);
            p_c     = ref_relu(w, 1'b1);
         end else begin
            pc_v    = 1'b0;
            pc_done = 1'b0;
         end
      end
      @(negedge clk);
      checkc();
      if (vc) nv++;
      if (dc) nd++;
      v56 = 1'b0;
      pc_v = 1'b0;
      pc_done = 1'b0;
      @(negedge clk);
      checkc();
      chk("count_out_c",  32'(nv), 32'd784);
      chk("count_done_c", 32'(nd), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
